// File: rtl/vreg_access_ctrl.sv
// +--------------------------------------------------------------------------+
// | vreg_access_ctrl: round-robin sharing of the vector register file between |
// | the parallel execute port and the serial load/store stream.  Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module vreg_access_ctrl #(
  parameter int NUM_ELEM = 16,
  parameter int ADDR_W   = 3
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ExReq,
  input  logic              ExWrite,
  input  logic [ADDR_W-1:0] ExAddr,
  input  logic [ADDR_W-1:0] ExAddr2,
  output logic              ExGrant,
  output logic              ExDone,
  input  logic              LsReq,
  input  logic              LsWrite,
  input  logic [ADDR_W-1:0] LsAddr,
  output logic              LsGrant,
  output logic              LsBeat,
  output logic [3:0]        LsIdx,
  output logic              LsDone,
  output logic              RF_RD_p,
  output logic              RF_WR_p,
  output logic              RF_RD_s,
  output logic              RF_WR_s,
  output logic [ADDR_W-1:0] RF_Addr,
  output logic [ADDR_W-1:0] RF_Addr2
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ELEM - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PAR      = 3'd1,
    ST_SER      = 3'd2,
    ST_SER_TAIL = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic                own_ls_q, own_ls_d;
  logic                fav_ex_q, fav_ex_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   addr2_q, addr2_d;
  logic                ex_grant_q, ex_grant_d;
  logic                ls_grant_q, ls_grant_d;
  logic                ex_done_q, ex_done_d;
  logic                ls_done_q, ls_done_d;
  logic                rd_p_q, rd_p_d;
  logic                wr_p_q, wr_p_d;
  logic                rd_s_q, rd_s_d;
  logic                wr_s_q, wr_s_d;
  logic                ls_beat_q, ls_beat_d;
  logic [3:0]          ls_idx_q, ls_idx_d;

  logic                win_ex;
  logic                win_ls;

  assign win_ex = ExReq & (~LsReq | fav_ex_q);
  assign win_ls = LsReq & (~ExReq | ~fav_ex_q);

  // Every output is decoded from the current state and registered, so the
  // visible strobes trail the state by one cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    own_ls_d   = own_ls_q;
    fav_ex_d   = fav_ex_q;
    addr_d     = addr_q;
    addr2_d    = addr2_q;
    ex_grant_d = 1'b0;
    ls_grant_d = 1'b0;
    ex_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    rd_p_d     = 1'b0;
    wr_p_d     = 1'b0;
    rd_s_d     = 1'b0;
    wr_s_d     = 1'b0;
    ls_beat_d  = 1'b0;
    ls_idx_d   = 4'd0;

    case (state_q)
      ST_IDLE: begin
        if (win_ex) begin
          state_d    = ST_PAR;
          ex_grant_d = 1'b1;
          wr_d       = ExWrite;
          own_ls_d   = 1'b0;
          fav_ex_d   = 1'b0;
          addr_d     = ExAddr;
          addr2_d    = ExAddr2;
        end else if (win_ls) begin
          state_d    = ST_SER;
          ls_grant_d = 1'b1;
          wr_d       = LsWrite;
          own_ls_d   = 1'b1;
          fav_ex_d   = 1'b1;
          addr_d     = LsAddr;
          addr2_d    = LsAddr;
          cnt_d      = 4'd0;
        end
      end

      ST_PAR: begin
        rd_p_d  = ~wr_q;
        wr_p_d  = wr_q;
        state_d = ST_DONE;
      end

      ST_SER: begin
        rd_s_d = ~wr_q;
        wr_s_d = wr_q;
        // Read data appears one cycle after its strobe, so read beats lag.
        if (wr_q) begin
          ls_beat_d = 1'b1;
          ls_idx_d  = cnt_q;
        end else if (cnt_q != 4'd0) begin
          ls_beat_d = 1'b1;
          ls_idx_d  = cnt_q - 4'd1;
        end
        if (cnt_q == LAST_IDX) begin
          cnt_d   = 4'd0;
          state_d = ST_SER_TAIL;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_SER_TAIL: begin
        if (!wr_q) begin
          ls_beat_d = 1'b1;
          ls_idx_d  = LAST_IDX;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        ex_done_d = ~own_ls_q;
        ls_done_d = own_ls_q;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      own_ls_q   <= 1'b0;
      fav_ex_q   <= 1'b1;
      addr_q     <= '0;
      addr2_q    <= '0;
      ex_grant_q <= 1'b0;
      ls_grant_q <= 1'b0;
      ex_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      rd_p_q     <= 1'b0;
      wr_p_q     <= 1'b0;
      rd_s_q     <= 1'b0;
      wr_s_q     <= 1'b0;
      ls_beat_q  <= 1'b0;
      ls_idx_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      own_ls_q   <= own_ls_d;
      fav_ex_q   <= fav_ex_d;
      addr_q     <= addr_d;
      addr2_q    <= addr2_d;
      ex_grant_q <= ex_grant_d;
      ls_grant_q <= ls_grant_d;
      ex_done_q  <= ex_done_d;
      ls_done_q  <= ls_done_d;
      rd_p_q     <= rd_p_d;
      wr_p_q     <= wr_p_d;
      rd_s_q     <= rd_s_d;
      wr_s_q     <= wr_s_d;
      ls_beat_q  <= ls_beat_d;
      ls_idx_q   <= ls_idx_d;
    end
  end

  assign ExGrant  = ex_grant_q;
  assign ExDone   = ex_done_q;
  assign LsGrant  = ls_grant_q;
  assign LsDone   = ls_done_q;
  assign LsBeat   = ls_beat_q;
  assign LsIdx    = ls_idx_q;
  assign RF_RD_p  = rd_p_q;
  assign RF_WR_p  = wr_p_q;
  assign RF_RD_s  = rd_s_q;
  assign RF_WR_s  = wr_s_q;
  assign RF_Addr  = addr_q;
  assign RF_Addr2 = addr2_q;

endmodule

`default_nettype wire

// File: tb/tb_vreg_access_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_vreg_access_ctrl: scoreboard bench with a behavioural register file.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vreg_access_ctrl;

  localparam int NUM_ELEM = 16;
  localparam int ADDR_W   = 3;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              ExReq = 1'b0, ExWrite = 1'b0;
  logic [ADDR_W-1:0] ExAddr = '0, ExAddr2 = '0;
  logic              ExGrant, ExDone;
  logic              LsReq = 1'b0, LsWrite = 1'b0;
  logic [ADDR_W-1:0] LsAddr = '0;
  logic              LsGrant, LsBeat, LsDone;
  logic [3:0]        LsIdx;
  logic              RF_RD_p, RF_WR_p, RF_RD_s, RF_WR_s;
  logic [ADDR_W-1:0] RF_Addr, RF_Addr2;

  vreg_access_ctrl #(.NUM_ELEM(NUM_ELEM), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ExReq(ExReq), .ExWrite(ExWrite), .ExAddr(ExAddr), .ExAddr2(ExAddr2),
    .ExGrant(ExGrant), .ExDone(ExDone),
    .LsReq(LsReq), .LsWrite(LsWrite), .LsAddr(LsAddr),
    .LsGrant(LsGrant), .LsBeat(LsBeat), .LsIdx(LsIdx), .LsDone(LsDone),
    .RF_RD_p(RF_RD_p), .RF_WR_p(RF_WR_p), .RF_RD_s(RF_RD_s), .RF_WR_s(RF_WR_s),
    .RF_Addr(RF_Addr), .RF_Addr2(RF_Addr2)
  );

  always #5 Clk = ~Clk;

  int   cyc = 0;
  logic rst_edge = 1'b1;
  always @(posedge Clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !Rst_n;
  end

  // Behavioural register file driven only by the controller's strobes.
  logic [255:0] rf_mem [8];
  logic         rf_ready = 1'b0;
  logic [255:0] ex_wdata = '0;
  logic [15:0]  ls_base = '0;
  logic [15:0]  ls_din;
  logic [255:0] dout_p, dout2_p;
  logic [15:0]  dout_s;
  int           es = 0;

  always_comb ls_din = LsBeat ? 16'(ls_base + {12'd0, LsIdx}) : 16'h0;

  always @(posedge Clk) begin
    if (!rf_ready) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
      rf_ready <= 1'b1;
    end else begin
      if (RF_WR_p) rf_mem[RF_Addr] <= ex_wdata;
      if (RF_RD_p) begin
        dout_p  <= rf_mem[RF_Addr];
        dout2_p <= rf_mem[RF_Addr2];
      end
      if (RF_WR_s) rf_mem[RF_Addr][es*16 +: 16] <= ls_din;
      if (RF_RD_s) dout_s <= rf_mem[RF_Addr][es*16 +: 16];
      es <= (RF_RD_s || RF_WR_s) ? (es + 1) % NUM_ELEM : 0;
    end
  end

  typedef struct {
    bit           is_ls;
    bit           wr;
    logic [2:0]   a;
    logic [2:0]   a2;
    logic [255:0] exp;
    logic [255:0] exp2;
    int           gcyc;
  } txn_t;

  txn_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Expected visible outputs k cycles after a grant, straight from the
  // transaction timeline: grant, strobe(s), optional tail beat, done.
  function automatic logic [12:0] exp_outs(input txn_t t, input int k);
    logic exg, lsg, rdp, wrp, rds, wrs, bt, exd, lsd;
    logic [3:0] idx;
    exg = 0; lsg = 0; rdp = 0; wrp = 0; rds = 0; wrs = 0; bt = 0; exd = 0; lsd = 0;
    idx = 4'd0;
    if (!t.is_ls) begin
      exg = (k == 0);
      rdp = (k == 1) && !t.wr;
      wrp = (k == 1) && t.wr;
      exd = (k == 2);
    end else begin
      lsg = (k == 0);
      rds = (k >= 1) && (k <= NUM_ELEM) && !t.wr;
      wrs = (k >= 1) && (k <= NUM_ELEM) && t.wr;
      if (t.wr && k >= 1 && k <= NUM_ELEM) begin bt = 1; idx = 4'(k - 1); end
      if (!t.wr && k >= 2 && k <= NUM_ELEM + 1) begin bt = 1; idx = 4'(k - 2); end
      lsd = (k == NUM_ELEM + 2);
    end
    return {exg, lsg, rdp, wrp, rds, wrs, bt, idx, exd, lsd};
  endfunction

  bit           act = 0;
  txn_t         cur;
  int           mon_k;
  logic [12:0]  mon_got, mon_exp;
  logic [255:0] mon_tmp;

  always @(negedge Clk) begin
    mon_got = {ExGrant, LsGrant, RF_RD_p, RF_WR_p, RF_RD_s, RF_WR_s,
               LsBeat, LsIdx, ExDone, LsDone};
    if (rst_edge) begin
      act = 0;
      exp_q.delete();
      chk("reset_outputs", 256'({mon_got, RF_Addr, RF_Addr2}), 256'(0));
    end else begin
      if (!act && exp_q.size() > 0 && cyc >= exp_q[0].gcyc) begin
        chk("grant_schedule", 256'(cyc), 256'(exp_q[0].gcyc));
        cur = exp_q.pop_front();
        act = 1;
      end
      mon_k   = act ? cyc - cur.gcyc : 0;
      mon_exp = act ? exp_outs(cur, mon_k) : 13'd0;
      chk("cycle_outputs", 256'(mon_got), 256'(mon_exp));
      if (act) begin
        chk("rf_addr", 256'({RF_Addr, RF_Addr2}), 256'({cur.a, cur.a2}));
        if (!cur.is_ls && !cur.wr && mon_k == 2) begin
          chk("par_read_data", dout_p, cur.exp);
          chk("par_read_data2", dout2_p, cur.exp2);
        end
        if (cur.is_ls && !cur.wr && mon_k >= 2 && mon_k <= NUM_ELEM + 1) begin
          mon_tmp = cur.exp;
          chk("ser_read_elem", 256'(dout_s), 256'(mon_tmp[(mon_k-2)*16 +: 16]));
        end
        if (mon_k >= (cur.is_ls ? NUM_ELEM + 2 : 2)) act = 0;
      end
    end
  end

  // Reference model state: vector contents and the arbitration preference.
  logic [255:0] ref_mem [8];
  bit           fav_ex = 1;

  task automatic round(input int ex_cnt, input int ls_cnt,
                       input bit exwr, input logic [2:0] exa, input logic [2:0] exa2,
                       input logic [255:0] exd,
                       input bit lswr, input logic [2:0] lsa, input logic [15:0] lsb,
                       input int idle);
    int   ex_rem, ls_rem, g, last, ex_seen, ls_seen;
    bit   take_ex;
    txn_t t;
    repeat (idle) @(negedge Clk);
    ex_rem = ex_cnt; ls_rem = ls_cnt;
    g = cyc + 1; last = cyc;
    while (ex_rem + ls_rem > 0) begin
      take_ex = (ex_rem > 0) && (ls_rem == 0 || fav_ex);
      if (take_ex) begin
        if (exwr) ref_mem[exa] = exd;
        t.is_ls = 0; t.wr = exwr; t.a = exa; t.a2 = exa2;
        t.exp = ref_mem[exa]; t.exp2 = ref_mem[exa2];
        t.gcyc = g; last = g + 2;
        fav_ex = 0; ex_rem--;
      end else begin
        if (lswr) for (int i = 0; i < NUM_ELEM; i++) ref_mem[lsa][i*16 +: 16] = 16'(lsb + 16'(i));
        t.is_ls = 1; t.wr = lswr; t.a = lsa; t.a2 = lsa;
        t.exp = ref_mem[lsa]; t.exp2 = ref_mem[lsa];
        t.gcyc = g; last = g + NUM_ELEM + 2;
        fav_ex = 1; ls_rem--;
      end
      exp_q.push_back(t);
      g = last + 1;
    end
    ExReq = (ex_cnt > 0); ExWrite = exwr; ExAddr = exa; ExAddr2 = exa2; ex_wdata = exd;
    LsReq = (ls_cnt > 0); LsWrite = lswr; LsAddr = lsa; ls_base = lsb;
    ex_seen = 0; ls_seen = 0;
    while (cyc < last) begin
      @(negedge Clk);
      if (ExGrant) begin ex_seen++; if (ex_seen >= ex_cnt) ExReq = 0; end
      if (LsGrant) begin ls_seen++; if (ls_seen >= ls_cnt) LsReq = 0; end
    end
    ExReq = 0; LsReq = 0;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    int   found;
    txn_t t;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    Rst_n = 0;
    repeat (3) @(negedge Clk);
    Rst_n = 1;
    fav_ex = 1;

    // Directed: parallel write/read, serial write/read, chained arbitration.
    round(1, 0, 1, 3'd2, 3'd0, rnd256(), 0, 3'd0, 16'h0, 1);
    round(1, 0, 0, 3'd2, 3'd5, '0, 0, 3'd0, 16'h0, 0);
    round(0, 1, 0, 3'd0, 3'd0, '0, 1, 3'd0, 16'hA000, 2);
    round(0, 1, 0, 3'd0, 3'd0, '0, 0, 3'd0, 16'h0, 0);
    round(2, 2, 0, 3'd2, 3'd0, '0, 0, 3'd2, 16'h0, 1);

    // Reset in the middle of a serial read, around beat 7.
    @(negedge Clk);
    t.is_ls = 1; t.wr = 0; t.a = 3'd3; t.a2 = 3'd3;
    t.exp = ref_mem[3]; t.exp2 = ref_mem[3]; t.gcyc = cyc + 1;
    exp_q.push_back(t);
    LsReq = 1; LsWrite = 0; LsAddr = 3'd3;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge Clk);
      if (LsGrant) LsReq = 0;
      if (LsBeat && LsIdx == 4'd7) found = 1;
    end
    chk("beat7_reached", 256'(found), 256'(1));
    LsReq = 0;
    Rst_n = 0;
    fav_ex = 1;
    @(negedge Clk);
    Rst_n = 1;
    round(1, 1, 1, 3'd5, 3'd1, rnd256(), 0, 3'd0, 16'h0, 1);

    for (int r = 0; r < 30; r++) begin
      int mode;
      mode = $urandom_range(1, 3);
      round((mode != 2) ? $urandom_range(1, 2) : 0,
            (mode != 1) ? $urandom_range(1, 2) : 0,
            1'($urandom), 3'($urandom), 3'($urandom), rnd256(),
            1'($urandom), 3'($urandom), 16'($urandom),
            $urandom_range(0, 2));
    end

    repeat (3) @(negedge Clk);
    for (int i = 0; i < 8; i++) chk("final_vreg", rf_mem[i], ref_mem[i]);
    chk("scoreboard_drained", 256'({act, 31'(exp_q.size())}), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/vreg_access_ctrl.md
Name: vreg_access_ctrl

Overview:
- Controller that shares the 8x16x16-bit vector register file between two requesters: the vector execute unit (single-cycle 256-bit parallel read/write) and the load/store unit (16-beat serial element stream).
- Arbitrates round-robin, sequences the register file strobes (RD_p/WR_p/RD_s/WR_s) and addresses, counts serial elements, and returns grant/beat/done handshakes.
- Sits between the issue logic and the register file. All register-file control outputs are registered.

Parameters:
- NUM_ELEM, 16, elements per vector; also the serial beat count.
- ADDR_W, 3, vector register address width.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  synchronous reset, active-low.
- ExReq  in  1  execute unit requests a parallel access.
- ExWrite  in  1  1 = parallel write, 0 = parallel read.
- ExAddr  in  ADDR_W  primary vector register.
- ExAddr2  in  ADDR_W  second read port register.
- ExGrant  out  1  one-cycle pulse when the Ex request is accepted.
- ExDone  out  1  one-cycle pulse: write committed, or parallel read data valid at the register file.
- LsReq  in  1  load/store unit requests a serial access.
- LsWrite  in  1  1 = serial write, 0 = serial read.
- LsAddr  in  ADDR_W  vector register for the serial access.
- LsGrant  out  1  one-cycle pulse when the Ls request is accepted.
- LsBeat  out  1  element strobe (see Behaviour).
- LsIdx  out  4  element index for the current beat.
- LsDone  out  1  one-cycle pulse after the last beat.
- RF_RD_p, RF_WR_p, RF_RD_s, RF_WR_s  out  1 each  register file strobes.
- RF_Addr, RF_Addr2  out  ADDR_W  register file addresses.

Behaviour:
- Reset (Rst_n=0 at a Clk edge):
  - state IDLE; all strobes, grants, dones and LsBeat = 0.
  - LsIdx = 0; RF_Addr = RF_Addr2 = 0; round-robin pointer favours Ex.
  - Reset mid-transaction aborts it at that edge. No done pulse is issued.
- States: IDLE, PAR, SER, SER_TAIL, DONE.
- IDLE:
  - Requests are sampled here only.
  - Ex only -> PAR. Ls only -> SER.
  - Both -> the favoured requester wins; the pointer flips to the other requester after every grant.
  - On the transition edge: pulse the winner's grant; latch write flag and addresses into RF_Addr/RF_Addr2. For Ls, RF_Addr2 = LsAddr.
- PAR (1 cycle):
  - RF_RD_p = ~wr or RF_WR_p = wr; → DONE.
  - ExDone pulses in the DONE cycle (one cycle after the strobe, when the register file output is valid).
- SER (NUM_ELEM cycles):
  - RF_RD_s or RF_WR_s held continuously high.
  - Element counter runs 0..15 and wraps to 0 on exit.
  - Write: LsBeat = 1 every SER cycle and LsIdx = counter. The Ls unit must present element LsIdx on DataIn_s in that same cycle.
  - Read: LsBeat/LsIdx are the counter delayed by one cycle, i.e. beats run over SER cycles 1..15 plus the SER_TAIL cycle. Element LsIdx is valid on DataOut_s/DataOut2_s during the beat.
  - After the 16th cycle → SER_TAIL.
- SER_TAIL (1 cycle):
  - Strobes low. Final read beat (LsIdx=15) if reading; nothing if writing.
  - → DONE.
- DONE (1 cycle):
  - Pulse the matching done (ExDone or LsDone); → IDLE.
  - Guarantees at least 2 strobe-low cycles between serial transactions, so the register file's element select restarts at 0.
- Invariants:
  - At most one RF strobe is high in any cycle.
  - RF_Addr/RF_Addr2 are stable from grant through DONE.
  - Requests are ignored outside IDLE. Dropping a request after grant does not abort the transaction.
  - A requester may keep its request high to chain transactions. With both requesting continuously, grants alternate Ex, Ls, Ex, ...
- Latency:
  - Parallel: grant → done = 2 cycles.
  - Serial: grant → done = NUM_ELEM+2 cycles.
  - Minimum IDLE residency is 1 cycle.

Test Plan:
- Ex parallel write, ExAddr=2 → RF_WR_p high exactly 1 cycle with RF_Addr=2; ExDone 2 cycles after ExGrant. A follow-up read of v2 through the register file returns the written 256-bit value.
- Ls serial write, LsAddr=0, data 16'hA000+LsIdx → RF_WR_s high 16 consecutive cycles; LsIdx 0..15 aligned with strobe; LsDone one cycle after SER_TAIL. A serial read of v0 then yields A000..A00F on beats LsIdx 0..15 (beats offset one cycle from RF_RD_s).
- ExReq and LsReq asserted together and held from reset → grant order Ex, Ls, Ex, Ls. Never two strobes high; exactly 1+2 idle/done cycles separate transactions.
- LsReq dropped in the cycle after LsGrant → transaction still completes all 16 beats and LsDone.
- Rst_n=0 at serial beat 7 → next cycle all strobes 0, LsIdx=0, no LsDone. A new LsReq after reset starts at LsIdx 0 and is granted before a simultaneous ExReq only if Ex was not favoured (reset favours Ex).
- Ex parallel read with ExAddr=2, ExAddr2=5 → RF_RD_p 1 cycle, RF_Addr=2, RF_Addr2=5; ExDone coincides with valid DataOut_p/DataOut2_p.
